// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter slice.
package arb_pkg;

    localparam int unsigned N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] decode(input logic [1:0] idx);
        decode      = '0;
        decode[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request after ptr, wrapping, ptr itself last.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       win_idx
);

    logic [1:0] idx;

    always_comb begin
        any     = 1'b0;
        win_idx = ptr;
        idx     = ptr;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!any && req[idx]) begin
                any     = 1'b1;
                win_idx = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant, release handshake,
// a mandatory turnaround cycle after each release and an optional hold-time limit.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic             any;
    logic [1:0]       win_idx;
    logic             owner_req;
    logic             hold_hit;

    rr_pick u_pick (
        .req     (req),
        .ptr     (ptr),
        .any     (any),
        .win_idx (win_idx)
    );

    assign owner_req = req[grant_idx];
    assign hold_hit  = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 2'd3;
            cnt         <= '0;
            grant       <= '0;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state       <= OWN;
                        grant_idx   <= win_idx;
                        grant       <= decode(win_idx);
                        grant_valid <= 1'b1;
                        cnt         <= '0;
                        ptr         <= win_idx;
                    end
                end
                OWN: begin
                    if (done || !owner_req || hold_hit) begin
                        state       <= GAP;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        // Done or withdraw wins; only a pure limit expiry is flagged.
                        timeout     <= !done && owner_req;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
